// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage : MEM pipeline stage
//
// Takes the EX/MEM register outputs, issues data-memory requests on a simple
// req/ack bus, resolves the branch/jump PC redirect and owns the MEM/WB
// pipeline register. While a load/store waits for its acknowledge the stage
// raises MEM_Stall (upstream holds EX/MEM) and writes bubbles into MEM/WB.
//
// Optional build macro: MEM_TIMEOUT_EN
//   defined   : a WAIT that sees no ack for TIMEOUT_CYCLES cycles is aborted,
//               completes with read data 32'hDEADBEEF and RegWrite_out forced
//               low, and mem_err pulses for one cycle.
//   undefined : WAIT lasts until ack; mem_err is tied low.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   *_in                      EX/MEM register contents
//   dmem_req/we/addr/wdata    memory request (address forced word aligned)
//   dmem_ack/rdata            memory acknowledge and load data
//   PCSrc, pc_target          PC redirect, combinational from EX/MEM
//   MEM_Stall                 hold IF..EX/MEM while an access is outstanding
//   mem_err                   timeout pulse
//   *_out                     MEM/WB register contents
//   wb_data_out               write-back value selected by MemtoReg_out
//
// FSM states
//   state  | meaning
//   S_IDLE | no access outstanding; requests issue straight from EX/MEM
//   S_WAIT | access outstanding; request driven from captured values
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int WIDTH          = 32,
    parameter int REG_ADDR_W     = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  RegWrite_in,
    input  logic [1:0]            MemtoReg_in,
    input  logic                  Branch_in,
    input  logic                  MemRead_in,
    input  logic                  MemWrite_in,
    input  logic                  Jump_in,
    input  logic [WIDTH-1:0]      jump_addr_in,
    input  logic [WIDTH-1:0]      branch_addr_in,
    input  logic                  ALU_zero_in,
    input  logic [WIDTH-1:0]      ALU_result_in,
    input  logic [WIDTH-1:0]      reg_read_data_2_in,
    input  logic [WIDTH-1:0]      pc_plus4_in,
    input  logic [REG_ADDR_W-1:0] EX_MEM_RegisterRd_in,

    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [WIDTH-1:0]      dmem_addr,
    output logic [WIDTH-1:0]      dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [WIDTH-1:0]      dmem_rdata,

    output logic                  PCSrc,
    output logic [WIDTH-1:0]      pc_target,
    output logic                  MEM_Stall,
    output logic                  mem_err,

    output logic                  RegWrite_out,
    output logic [1:0]            MemtoReg_out,
    output logic [WIDTH-1:0]      mem_read_data_out,
    output logic [WIDTH-1:0]      ALU_result_out,
    output logic [WIDTH-1:0]      pc_plus4_out,
    output logic [REG_ADDR_W-1:0] MEM_WB_RegisterRd_out,
    output logic [WIDTH-1:0]      wb_data_out
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // What the MEM/WB register loads on the next edge.
    localparam logic [1:0] WB_BUBBLE  = 2'd0;
    localparam logic [1:0] WB_INPUTS  = 2'd1;
    localparam logic [1:0] WB_LATCHED = 2'd2;
    localparam logic [1:0] WB_TIMEOUT = 2'd3;

    state_t state, state_nxt;

    logic                  mem_op;
    logic                  req_c;
    logic                  stall_c;
    logic                  capture;
    logic [1:0]            wb_act;

    // Access captured on entry to S_WAIT; EX/MEM inputs are ignored while waiting.
    logic                  lat_we;
    logic                  lat_reg_write;
    logic [1:0]            lat_mem_to_reg;
    logic [WIDTH-1:0]      lat_alu;
    logic [WIDTH-1:0]      lat_wdata;
    logic [WIDTH-1:0]      lat_pc_plus4;
    logic [REG_ADDR_W-1:0] lat_rd;

    logic                  timeout_hit;

    assign mem_op = MemRead_in | MemWrite_in;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Down-counter loaded with TIMEOUT_CYCLES-1 on entry to S_WAIT; the WAIT
    // cycle that finds it at zero is the last one before the abort.
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign timeout_hit = (state == S_WAIT) && !dmem_ack && (wait_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (capture) begin
                wait_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
            end else if (state == S_WAIT) begin
                if (dmem_ack || timeout_hit) begin
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt - 1'b1;
                end
            end
        end
    end

    assign mem_err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
    assign mem_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        capture    = 1'b0;
        wb_act     = WB_INPUTS;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;

        case (state)
            S_IDLE: begin
                dmem_addr  = {ALU_result_in[WIDTH-1:2], 2'b00};
                dmem_wdata = reg_read_data_2_in;
                dmem_we    = MemWrite_in;
                req_c      = mem_op;
                if (mem_op && !dmem_ack) begin
                    stall_c   = 1'b1;
                    capture   = 1'b1;
                    wb_act    = WB_BUBBLE;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                dmem_addr  = {lat_alu[WIDTH-1:2], 2'b00};
                dmem_wdata = lat_wdata;
                dmem_we    = lat_we;
                req_c      = 1'b1;
                if (dmem_ack) begin
                    wb_act    = WB_LATCHED;
                    state_nxt = S_IDLE;
                end else if (timeout_hit) begin
                    // Abort completes at this edge, so upstream may advance now.
                    wb_act    = WB_TIMEOUT;
                    state_nxt = S_IDLE;
                end else begin
                    stall_c = 1'b1;
                    wb_act  = WB_BUBBLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Gated by reset so an asserted reset kills the request immediately even
    // if EX/MEM still presents a memory operation.
    assign dmem_req  = rst & req_c;
    assign MEM_Stall = rst & stall_c;

    assign PCSrc     = Jump_in | (Branch_in & ALU_zero_in);
    assign pc_target = Jump_in ? jump_addr_in : branch_addr_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_we         <= 1'b0;
            lat_reg_write  <= 1'b0;
            lat_mem_to_reg <= 2'b00;
            lat_alu        <= '0;
            lat_wdata      <= '0;
            lat_pc_plus4   <= '0;
            lat_rd         <= '0;
        end else if (capture) begin
            lat_we         <= MemWrite_in;
            lat_reg_write  <= RegWrite_in;
            lat_mem_to_reg <= MemtoReg_in;
            lat_alu        <= ALU_result_in;
            lat_wdata      <= reg_read_data_2_in;
            lat_pc_plus4   <= pc_plus4_in;
            lat_rd         <= EX_MEM_RegisterRd_in;
        end
    end

    // MEM/WB register. A bubble clears every field so nothing downstream can
    // act on stale data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWrite_out          <= 1'b0;
            MemtoReg_out          <= 2'b00;
            mem_read_data_out     <= '0;
            ALU_result_out        <= '0;
            pc_plus4_out          <= '0;
            MEM_WB_RegisterRd_out <= '0;
        end else begin
            case (wb_act)
                WB_INPUTS: begin
                    RegWrite_out          <= RegWrite_in;
                    MemtoReg_out          <= MemtoReg_in;
                    mem_read_data_out     <= dmem_rdata;
                    ALU_result_out        <= ALU_result_in;
                    pc_plus4_out          <= pc_plus4_in;
                    MEM_WB_RegisterRd_out <= EX_MEM_RegisterRd_in;
                end
                WB_LATCHED: begin
                    RegWrite_out          <= lat_reg_write;
                    MemtoReg_out          <= lat_mem_to_reg;
                    mem_read_data_out     <= dmem_rdata;
                    ALU_result_out        <= lat_alu;
                    pc_plus4_out          <= lat_pc_plus4;
                    MEM_WB_RegisterRd_out <= lat_rd;
                end
                WB_TIMEOUT: begin
                    RegWrite_out          <= 1'b0;
                    MemtoReg_out          <= lat_mem_to_reg;
                    mem_read_data_out     <= WIDTH'(32'hDEADBEEF);
                    ALU_result_out        <= lat_alu;
                    pc_plus4_out          <= lat_pc_plus4;
                    MEM_WB_RegisterRd_out <= lat_rd;
                end
                default: begin
                    RegWrite_out          <= 1'b0;
                    MemtoReg_out          <= 2'b00;
                    mem_read_data_out     <= '0;
                    ALU_result_out        <= '0;
                    pc_plus4_out          <= '0;
                    MEM_WB_RegisterRd_out <= '0;
                end
            endcase
        end
    end

    always_comb begin
        case (MemtoReg_out)
            2'b01:   wb_data_out = mem_read_data_out;
            2'b10:   wb_data_out = pc_plus4_out;
            default: wb_data_out = ALU_result_out;
        endcase
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage: consumes EX/MEM register outputs; drives the data-memory request/acknowledge bus; resolves branch/jump PC redirect; owns the MEM/WB pipeline register.
- Holds the pipeline via MEM_Stall while a load/store waits for memory; writes a bubble into MEM/WB until the access completes.

Parameters:
WIDTH, 32, data/address width
REG_ADDR_W, 5, register-file index width
TIMEOUT_CYCLES, 255, WAIT cycles before abort (MEM_TIMEOUT_EN only)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
RegWrite_in  in  1  from EX/MEM
MemtoReg_in  in  2  00 ALU result, 01 load data, 10 pc_plus4, 11 ALU result
Branch_in, MemRead_in, MemWrite_in, Jump_in  in  1 each  control from EX/MEM
jump_addr_in, branch_addr_in  in  WIDTH  redirect targets
ALU_zero_in  in  1  branch condition
ALU_result_in  in  WIDTH  ALU result / memory address
reg_read_data_2_in  in  WIDTH  store data
pc_plus4_in  in  WIDTH  link value
EX_MEM_RegisterRd_in  in  REG_ADDR_W  destination register
dmem_req  out  1  memory request valid
dmem_we  out  1  1 = write
dmem_addr  out  WIDTH  word-aligned address
dmem_wdata  out  WIDTH  store data
dmem_ack  in  1  request accepted/completed; read data valid
dmem_rdata  in  WIDTH  load data
PCSrc  out  1  redirect PC
pc_target  out  WIDTH  redirect address
MEM_Stall  out  1  hold IF..EX/MEM
mem_err  out  1  timeout pulse (0 without feature)
RegWrite_out  out  1  MEM/WB
MemtoReg_out  out  2  MEM/WB
mem_read_data_out, ALU_result_out, pc_plus4_out  out  WIDTH  MEM/WB
MEM_WB_RegisterRd_out  out  REG_ADDR_W  MEM/WB
wb_data_out  out  WIDTH  write-back value muxed from MEM/WB by MemtoReg_out

Behaviour:
- rst=0 (async): state IDLE; all registered outputs 0; dmem_req=0 immediately; wait counter 0.
- mem_op = MemRead_in | MemWrite_in. If both are set, treat it as a write (MemWrite priority).
- dmem_addr = {ALU_result[WIDTH-1:2], 2'b00}; dmem_wdata = reg_read_data_2. dmem_we = MemWrite.
- IDLE, mem_op=0: dmem_req=0; MEM_Stall=0; MEM/WB latches inputs next edge (latency 1).
- IDLE, mem_op=1:
  - dmem_req=1 combinationally from inputs.
  - dmem_ack=1 same cycle: zero-wait completion. MEM/WB latches inputs plus dmem_rdata; stay IDLE.
  - dmem_ack=0: MEM_Stall=1; latch addr/wdata/we/control; go to WAIT.
- WAIT: dmem_req=1 from latched values; MEM_Stall=1; MEM/WB receives a bubble (RegWrite_out=0, Rd=0) each edge.
  - On dmem_ack: MEM/WB latches latched control plus dmem_rdata; MEM_Stall drops combinationally that cycle; go to IDLE.
- Upstream EX/MEM holds its contents whenever MEM_Stall=1. Inputs are ignored in WAIT.
- dmem_ack while dmem_req=0 is ignored.
- Store completion: RegWrite_out is passed through as supplied (normally 0); mem_read_data_out is loaded with dmem_rdata regardless.
- PCSrc = Jump_in | (Branch_in & ALU_zero_in), combinational, independent of stall.
- pc_target = Jump_in ? jump_addr_in : branch_addr_in (jump priority).
- wb_data_out:
  - MemtoReg_out 01 -> mem_read_data_out
  - 10 -> pc_plus4_out
  - else -> ALU_result_out
- Reset mid-WAIT: request abandoned, no MEM/WB update, IDLE after release.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - WAIT counter increments per cycle without ack.
  - At TIMEOUT_CYCLES: drop dmem_req; complete with mem_read_data_out=32'hDEADBEEF and RegWrite_out forced 0; mem_err=1 for one cycle; return to IDLE; counter clears.
  - Ack on the terminal cycle wins over timeout.
- Undefined: no counter; WAIT persists until ack; mem_err tied 0.

Test Plan:
- Reset: rst=0 mid-WAIT with dmem_req=1 -> dmem_req=0 same cycle, all MEM/WB outputs 0, MEM_Stall=0.
- Zero-wait load: MemRead=1, ALU_result=0x0000_1006, Rd=5, MemtoReg=01, dmem_ack=1, rdata=0xCAFE_F00D same cycle -> dmem_addr=0x0000_1004; next edge RegWrite_out=1, Rd_out=5, wb_data_out=0xCAFE_F00D; MEM_Stall never 1.
- 3-wait store: MemWrite=1, addr 0x20, data 0x1234_5678, ack on 4th cycle -> dmem_req/we high 4 cycles with constant addr/wdata; MEM_Stall=1 for the first 3 cycles, 0 on the ack cycle; 3 bubbles into MEM/WB (RegWrite_out=0).
- Branch/jump: Branch=1, zero=1, branch_addr=0x40 -> PCSrc=1, pc_target=0x40; add Jump=1, jump_addr=0x80 -> pc_target=0x80; Branch=1, zero=0, Jump=0 -> PCSrc=0.
- ALU/link pass-through: MemtoReg=10, pc_plus4=0x104, RegWrite=1, Rd=31, no mem op -> next edge wb_data_out=0x104, Rd_out=31.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, load never acked -> dmem_req drops after 4 WAIT cycles, mem_err one-cycle pulse, mem_read_data_out=0xDEADBEEF, RegWrite_out=0, MEM_Stall released.
